// File: rtl/grade_sched.sv
// Round-robin scheduler that shares one ap_ctrl_hs grade core between NREQ
// requesters, returning tagged 8-bit grades and aborting hung jobs by watchdog.
module grade_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_p,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*32-1:0]   req_c,
    input  logic [NREQ*32-1:0]   req_m,
    input  logic [NREQ*32-1:0]   req_cs,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 rsp_timeout,
    output logic                 core_start,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic                 core_idle,
    output logic [31:0]          core_p,
    output logic [31:0]          core_b,
    output logic [31:0]          core_c,
    output logic [31:0]          core_m,
    output logic [31:0]          core_cs,
    input  logic [7:0]           core_return,
    output logic                 busy
);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_last;
    logic [WDW-1:0]  r_wdog;
    logic [IDW-1:0]  r_rsp_id;
    logic [7:0]      r_rsp_data;
    logic            r_rsp_timeout;
    logic [31:0]     r_core_p, r_core_b, r_core_c, r_core_m, r_core_cs;

    logic            w_any;
    logic [IDW-1:0]  w_gnt;
    int unsigned     w_idx;
    logic [31:0]     w_p, w_b, w_c, w_m, w_cs;
    logic            w_grant;
    logic            w_done_ok;
    logic            w_abort;
    logic            w_wd_hit;

    // Search starts one past the previous grant and wraps, giving round-robin fairness.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = 32'(r_last) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_any && req_valid[w_idx[IDW-1:0]]) begin
                w_any = 1'b1;
                w_gnt = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_p  = '0;
        w_b  = '0;
        w_c  = '0;
        w_m  = '0;
        w_cs = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_gnt == IDW'(k)) begin
                w_p  = req_p[32*k +: 32];
                w_b  = req_b[32*k +: 32];
                w_c  = req_c[32*k +: 32];
                w_m  = req_m[32*k +: 32];
                w_cs = req_cs[32*k +: 32];
            end
        end
    end

    assign w_grant  = (r_state == IDLE) && w_any;
    assign w_wd_hit = (r_wdog == WDW'(TIMEOUT - 1));

    always_comb begin
        req_ready = '0;
        if (w_grant) req_ready[w_gnt] = 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) r_state <= IDLE;
        else           r_state <= w_next;
    end

    // core_done is tested before the watchdog so a completion on the final cycle wins.
    always_comb begin
        w_next     = r_state;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (r_state != IDLE);
        w_done_ok  = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: if (w_any) w_next = START;
            START: begin
                core_start = 1'b1;
                if (core_done) begin
                    w_next    = RESP;
                    w_done_ok = 1'b1;
                end else if (w_wd_hit) begin
                    w_next  = RESP;
                    w_abort = 1'b1;
                end else if (core_ready) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (core_done) begin
                    w_next    = RESP;
                    w_done_ok = 1'b1;
                end else if (w_wd_hit) begin
                    w_next  = RESP;
                    w_abort = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = (r_rsp_timeout && !core_idle) ? DRAIN : IDLE;
            end
            DRAIN: if (core_idle) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_last        <= IDW'(NREQ - 1);
            r_wdog        <= '0;
            r_rsp_id      <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_core_p      <= '0;
            r_core_b      <= '0;
            r_core_c      <= '0;
            r_core_m      <= '0;
            r_core_cs     <= '0;
        end else begin
            if (w_grant) begin
                r_last    <= w_gnt;
                r_rsp_id  <= w_gnt;
                r_core_p  <= w_p;
                r_core_b  <= w_b;
                r_core_c  <= w_c;
                r_core_m  <= w_m;
                r_core_cs <= w_cs;
            end
            if (r_state == START || r_state == WAIT) begin
                if (r_wdog != WDW'(TIMEOUT)) r_wdog <= r_wdog + 1'b1;
            end else if (r_state == RESP && rsp_ready) begin
                r_wdog <= '0;
            end
            if (w_done_ok) begin
                r_rsp_data    <= core_return;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    assign core_p      = r_core_p;
    assign core_b      = r_core_b;
    assign core_c      = r_core_c;
    assign core_m      = r_core_m;
    assign core_cs     = r_core_cs;

endmodule

// File: tb/tb_grade_sched.sv
// Bench for grade_sched: directed and random jobs against a job-level reference
// model (round-robin pick, expected grade/timeout, response latency).
module tb_grade_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 15;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*32-1:0]   req_p, req_b, req_c, req_m, req_cs;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           rsp_data;
    logic                 rsp_timeout;
    logic                 core_start, core_ready, core_done, core_idle;
    logic [31:0]          core_p, core_b, core_c, core_m, core_cs;
    logic [7:0]           core_return;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int last_g = NREQ - 1;

    // Core model: ready at c_rdy and done at c_dn cycles after start (c_dn<0: never).
    bit         man    = 1'b0;
    bit         c_busy = 1'b0;
    int         c_t    = 0;
    int         c_rdy  = 0;
    int         c_dn   = -1;
    logic [7:0] c_ret  = 8'h00;

    grade_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_b(req_b), .req_c(req_c), .req_m(req_m), .req_cs(req_cs),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
        .core_idle(core_idle),
        .core_p(core_p), .core_b(core_b), .core_c(core_c), .core_m(core_m), .core_cs(core_cs),
        .core_return(core_return), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench did not terminate");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic eval();
        #1;
        if (!man) begin
            if (core_start === 1'b1 && !c_busy) begin
                c_busy = 1'b1;
                c_t    = 0;
            end
            core_ready  = c_busy && (c_t == c_rdy);
            core_done   = c_busy && (c_dn >= 0) && (c_t == c_dn);
            core_return = core_done ? c_ret : 8'($urandom);
            core_idle   = !c_busy;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge ap_clk);
        if (!man && c_busy) begin
            if (core_done) c_busy = 1'b0;
            else           c_t++;
        end
        #1;
    endtask

    task automatic rand_ops();
        for (int k = 0; k < NREQ; k++) begin
            req_p[32*k +: 32]  = $urandom;
            req_b[32*k +: 32]  = $urandom;
            req_c[32*k +: 32]  = $urandom;
            req_m[32*k +: 32]  = $urandom;
            req_cs[32*k +: 32] = $urandom;
        end
    endtask

    function automatic logic [255:0] all_outs();
        return {req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout, core_start,
                core_p, core_b, core_c, core_m, core_cs, busy};
    endfunction

    task automatic run_job(input logic [NREQ-1:0] vmask, input int rdy_at, input int dn_at,
                           input logic [7:0] ret, input int hold, input bit keep);
        int              g, n, lat_exp, bad;
        bit              exp_to, exp_start, drain_exp;
        logic [7:0]      exp_data;
        logic [NREQ-1:0] exp_rdy;
        logic [159:0]    exp_ops;
        logic [IDW+8:0]  held;

        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick(); eval(); n++;
        end
        chk("idle_before_grant", busy, 0);
        req_valid = vmask;
        c_rdy = rdy_at; c_dn = dn_at; c_ret = ret;
        eval();
        g = -1;
        for (int k = 1; k <= NREQ; k++)
            if (g < 0 && vmask[(last_g + k) % NREQ]) g = (last_g + k) % NREQ;
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        chk("grant", req_ready, exp_rdy);
        exp_ops = {req_p[32*g +: 32], req_b[32*g +: 32], req_c[32*g +: 32],
                   req_m[32*g +: 32], req_cs[32*g +: 32]};
        if (dn_at >= 0 && dn_at < TMO) begin
            exp_to = 1'b0; exp_data = ret; lat_exp = dn_at + 2;
        end else begin
            exp_to = 1'b1; exp_data = 8'h00; lat_exp = TMO + 1;
        end
        last_g = g;
        tick();
        if (!keep) req_valid = '0;
        eval();
        n = 1; exp_start = 1'b1; bad = 0;
        while (rsp_valid !== 1'b1 && n < TMO + 40) begin
            if (core_start !== exp_start || req_ready !== '0) bad++;
            if (core_ready || core_done || n == TMO) exp_start = 1'b0;
            tick(); eval(); n++;
        end
        chk("start_seq", bad, 0);
        chk("latency", n, lat_exp);
        chk("resp", {rsp_valid, rsp_id, rsp_data, rsp_timeout}, {1'b1, IDW'(g), exp_data, exp_to});
        chk("operands", {core_p, core_b, core_c, core_m, core_cs}, exp_ops);
        held = {rsp_id, rsp_data, rsp_timeout};
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            tick(); eval();
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_data, rsp_timeout} !== held ||
                req_ready !== '0 || core_start !== 1'b0) bad++;
        end
        if (hold > 0) chk("hold_stable", bad, 0);
        rsp_ready = 1'b1;
        eval();
        drain_exp = exp_to && c_busy;
        tick();
        rsp_ready = 1'b0;
        eval();
        chk("after_handshake", {busy, rsp_valid}, {drain_exp, 1'b0});
        if (drain_exp && dn_at >= 0) begin
            n = 0; bad = 0;
            while (busy !== 1'b0 && n < 100) begin
                if (rsp_valid !== 1'b0 || req_ready !== '0) bad++;
                tick(); eval(); n++;
            end
            chk("drain_exit", busy, 0);
            chk("drain_quiet", bad, 0);
        end
    endtask

    initial begin
        int bad;
        int dn;
        core_ready = 1'b0; core_done = 1'b0; core_idle = 1'b1; core_return = 8'h00;
        req_valid = '0; rsp_ready = 1'b0;
        req_p = '0; req_b = '0; req_c = '0; req_m = '0; req_cs = '0;

        ap_rst_n = 1'b0;
        eval(); tick(); tick();
        ap_rst_n = 1'b1;
        eval();
        chk("reset_state", all_outs(), 0);

        // All requesters continuously valid: strict 0,1,2,3 rotation.
        rand_ops();
        for (int j = 0; j < 8; j++)
            run_job(4'hF, 0, $urandom_range(0, 5), 8'($urandom), 0, (j < 7));

        // Single job from requester 2 with fixed operands.
        rand_ops();
        req_p[64 +: 32] = 32'd90; req_b[64 +: 32] = 32'd5; req_c[64 +: 32] = 32'd3;
        req_m[64 +: 32] = 32'd1;  req_cs[64 +: 32] = 32'd0;
        run_job(4'b0100, 0, 2, 8'h41, 0, 1'b0);

        // Ready and done on the first start cycle.
        run_job(4'b0010, 0, 0, 8'h07, 0, 1'b0);

        // Response back-pressure, then immediate regrant.
        rand_ops();
        run_job(4'hF, 1, 3, 8'($urandom), 5, 1'b1);
        run_job(4'hF, 0, 1, 8'($urandom), 0, 1'b0);

        // Hung core: watchdog abort, drain, ignored late done.
        run_job(4'b0001, 0, -1, 8'hAA, 0, 1'b0);
        man = 1'b1;
        core_ready = 1'b0; core_done = 1'b0; core_idle = 1'b0;
        req_valid = '1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            core_done = (i == 4);
            eval();
            if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== '0) bad++;
            tick();
        end
        chk("drain_hold", bad, 0);
        core_done = 1'b0; core_idle = 1'b1; req_valid = '0;
        eval();
        chk("drain_last_cycle", busy, 1);
        tick(); eval();
        chk("drain_to_idle", {busy, rsp_valid}, 0);
        man = 1'b0; c_busy = 1'b0;
        eval();

        // Reset while the core is in WAIT.
        rand_ops();
        req_valid = 4'b0100; c_rdy = 0; c_dn = -1;
        eval();
        chk("rst_job_grant", req_ready, 4'b0100);
        last_g = 2;
        tick(); req_valid = '0; eval();
        tick(); eval();
        chk("in_wait", {busy, core_start, rsp_valid}, 3'b100);
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1; c_busy = 1'b0;
        eval();
        chk("reset_mid_job", all_outs(), 0);
        last_g = NREQ - 1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); eval();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("no_rsp_after_reset", bad, 0);
        run_job(4'b1001, 0, 1, 8'($urandom), 0, 1'b0);
        run_job(4'b1000, 0, 1, 8'($urandom), 0, 1'b0);

        // Random traffic, latencies spanning success and timeout.
        for (int j = 0; j < 40; j++) begin
            rand_ops();
            dn = $urandom_range(0, 20);
            run_job(4'($urandom_range(1, 15)), $urandom_range(0, dn), dn, 8'($urandom),
                    $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
